vending_ctrl: RTL and testbench
===============================

# vending_ctrl

Parametrised vending controller for the FPGA lab designs: a multi-product, multi-coin machine with credit accumulation, per-product stock tracking, cancel, and serial change return. It sits between the debounced/synchronised front-panel inputs (coin pulses, product buttons, cancel, refill) and the output drivers (dispense strobe, change-coin ejector, sold-out LEDs, credit display). All monetary values are in units of 100 won.

## Interface
- PRICE, 3: price of every product, in units; 1 ≤ PRICE ≤ MAX_CREDIT
- MAX_CREDIT, 10: maximum credit held, in units
- CREDIT_W, 4: credit register width; 2^CREDIT_W > MAX_CREDIT
- N_PROD, 2: number of products, 1–8
- STOCK_INIT, 8: stock per product after reset or refill
- STOCK_W, 4: stock counter width; 2^STOCK_W > STOCK_INIT

Ports:
- CLK  in  1  system clock, rising edge
- RSTn  in  1  asynchronous active-low reset
- w100  in  1  100-won coin, one-cycle pulse, 1 unit
- w500  in  1  500-won coin, one-cycle pulse, 5 units
- btn  in  N_PROD  product request, level; lowest set index wins
- cancel  in  1  return all credit, one-cycle pulse
- refill  in  1  reload all stock, one-cycle pulse
- sale  out  1  dispense strobe, high one cycle per sale
- sale_id  out  3  product index, valid while sale=1, else 0
- ret  out  1  eject one 100-won coin, one cycle per unit
- coin_rej  out  1  coin rejected (diverted to return chute), one cycle
- deny  out  1  request refused (low credit or sold out), one cycle
- credit  out  CREDIT_W  current credit
- sold_out  out  N_PROD  bit i = stock of product i is 0
- busy  out  1  high in VEND and CHANGE

## Operation
- States: IDLE, CREDIT, VEND, CHANGE. Reset: IDLE; credit 0, stock all STOCK_INIT, sold_out = (STOCK_INIT==0 ? all 1 : 0), all pulse outputs 0.
- Coin acceptance in IDLE/CREDIT: w500 evaluated before w100; each added only if credit+value ≤ MAX_CREDIT, else coin_rej. Both in one cycle: w500 first, w100 against updated sum. Any accepted coin in IDLE → CREDIT.
- CREDIT priority: cancel > btn > coins.
  - cancel: → CHANGE; coins this cycle rejected.
  - btn, credit ≥ PRICE, stock>0: credit −= PRICE, stock−1, → VEND; coins this cycle rejected.
  - btn, credit < PRICE or sold out: deny pulse, stay; coins still processed.
  - cancel/btn in IDLE: ignored (no deny).
- VEND (one cycle): sale=1, sale_id=index. Next: credit>0 → CHANGE, else IDLE.
- CHANGE: ret=1 every cycle; credit −1 per cycle; credit==1 → IDLE. Coins rejected, btn/cancel ignored.
- refill: honoured in IDLE and CREDIT only; all stock := STOCK_INIT, sold_out cleared. Ignored in VEND/CHANGE.
- Stock saturates at 0; never decremented when 0.
- Reset mid-operation: credit lost, no ret issued, stock restored to STOCK_INIT.

## Timing
- All outputs registered; input event at cycle n → visible at n+1.
- Coin at n: credit updated at n+1, coin_rej at n+1 on reject.
- Accepted btn at n: sale/sale_id at n+1, credit shows remainder at n+1, sold_out updated at n+1; first ret at n+2; ret high for exactly remainder cycles, consecutively.
- cancel at n with credit C: ret high n+1 … n+C; credit reaches 0 at n+C+1, IDLE.
- btn held through VEND/CHANGE: re-evaluated only after return to CREDIT (no repeat sale unless credit ≥ PRICE again).

## Structure
- Package vending_pkg: state encoding localparams (IDLE=2'd0, CREDIT=2'd1, VEND=2'd2, CHANGE=2'd3), coin values (W100_VAL=1, W500_VAL=5).
- Sub-module stock_counter (one per product via generate): load on refill, decrement enable, outputs count and empty flag.
- Top: FSM, credit arithmetic (CREDIT_W+1-bit sum for overflow check), priority encoder on btn.

## Test plan
- Defaults; w100, w100, w500 → credit 1,2,7; btn=2'b01 → sale=1 sale_id=0 one cycle, credit 4, then ret 4 consecutive cycles, IDLE, sold_out=00.
- credit 7, w500 → coin_rej=1, credit stays 7; w100 ×3 → credit 10, 4th w100 rejected.
- credit 2, btn=2'b10 → deny=1, credit 2, no sale; cancel → ret 2 cycles, credit 0.
- Sell product 1 eight times (exact price, credit 3 each) → sold_out=2'b10 after 8th; 9th request with credit 3 → deny; refill → sold_out=00.
- btn=2'b11 with credit 3 and w100 same cycle → sale_id=0, coin_rej=1, credit 0, no ret, IDLE.
- Cancel with credit 5, assert RSTn=0 after 2 ret pulses → credit 0, ret 0 immediately, stock all 8, IDLE.

Source files
------------

// File: rtl/vending_pkg.sv
// Shared state encoding and coin values for the vending controller.
package vending_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CREDIT = 2'd1,
    VEND   = 2'd2,
    CHANGE = 2'd3
  } state_t;

  localparam int W100_VAL = 1;
  localparam int W500_VAL = 5;

endpackage

// File: rtl/vending_ctrl_if.sv
// Front-panel inputs and driver outputs of the vending controller.
interface vending_ctrl_if #(
  parameter int N_PROD   = 2,
  parameter int CREDIT_W = 4
);
  logic                w100;
  logic                w500;
  logic [N_PROD-1:0]   btn;
  logic                cancel;
  logic                refill;
  logic                sale;
  logic [2:0]          sale_id;
  logic                ret;
  logic                coin_rej;
  logic                deny;
  logic [CREDIT_W-1:0] credit;
  logic [N_PROD-1:0]   sold_out;
  logic                busy;

  modport master (
    output w100, w500, btn, cancel, refill,
    input  sale, sale_id, ret, coin_rej, deny, credit, sold_out, busy
  );

  modport slave (
    input  w100, w500, btn, cancel, refill,
    output sale, sale_id, ret, coin_rej, deny, credit, sold_out, busy
  );
endinterface

// File: rtl/stock_counter.sv
// Per-product stock counter: reload on refill, saturating decrement.
module stock_counter #(
  parameter int STOCK_INIT = 8,
  parameter int STOCK_W    = 4
) (
  input  logic               CLK,
  input  logic               RSTn,
  input  logic               load,
  input  logic               dec,
  output logic [STOCK_W-1:0] count,
  output logic               empty
);

  localparam logic [STOCK_W-1:0] INIT_V = STOCK_W'(STOCK_INIT);

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      count <= INIT_V;
    end else if (load) begin
      count <= INIT_V;
    end else if (dec && count != '0) begin
      count <= count - 1'b1;
    end
  end

  assign empty = (count == '0);

endmodule

// File: rtl/vending_ctrl.sv
// Multi-product vending controller: credit accumulation, stock tracking,
// cancel and serial change return.
module vending_ctrl
  import vending_pkg::*;
#(
  parameter int PRICE      = 3,
  parameter int MAX_CREDIT = 10,
  parameter int CREDIT_W   = 4,
  parameter int N_PROD     = 2,
  parameter int STOCK_INIT = 8,
  parameter int STOCK_W    = 4
) (
  input logic           CLK,
  input logic           RSTn,
  vending_ctrl_if.slave bus
);

  localparam logic [CREDIT_W:0]   MAX_V   = (CREDIT_W+1)'(MAX_CREDIT);
  localparam logic [CREDIT_W:0]   W100_V  = (CREDIT_W+1)'(W100_VAL);
  localparam logic [CREDIT_W:0]   W500_V  = (CREDIT_W+1)'(W500_VAL);
  localparam logic [CREDIT_W-1:0] PRICE_V = CREDIT_W'(PRICE);

  state_t              state_q, state_n;
  logic [CREDIT_W-1:0] credit_q, credit_n;
  logic                rej_q, rej_n;
  logic                deny_q, deny_n;
  logic [2:0]          id_q, id_n;
  logic [N_PROD-1:0]   grant, dec, empty;
  logic                load;
  logic [STOCK_W-1:0]  cnt [N_PROD];
  logic [CREDIT_W:0]   acc;
  logic                acc_rej;
  logic                coins;
  logic                in_stock;
  logic [2:0]          sel_id;

  for (genvar g = 0; g < N_PROD; g++) begin : g_stock
    stock_counter #(
      .STOCK_INIT(STOCK_INIT),
      .STOCK_W   (STOCK_W)
    ) u_stock (
      .CLK  (CLK),
      .RSTn (RSTn),
      .load (load),
      .dec  (dec[g]),
      .count(cnt[g]),
      .empty(empty[g])
    );
  end

  // w500 is tried first; w100 is then checked against the updated sum.
  always_comb begin
    acc     = {1'b0, credit_q};
    acc_rej = 1'b0;
    if (bus.w500) begin
      if (acc + W500_V <= MAX_V) acc = acc + W500_V;
      else                       acc_rej = 1'b1;
    end
    if (bus.w100) begin
      if (acc + W100_V <= MAX_V) acc = acc + W100_V;
      else                       acc_rej = 1'b1;
    end
  end

  assign coins = bus.w100 | bus.w500;
  assign grant = bus.btn & (~bus.btn + N_PROD'(1));

  always_comb begin
    in_stock = 1'b0;
    sel_id   = '0;
    for (int unsigned i = 0; i < N_PROD; i++) begin
      if (grant[i]) begin
        sel_id   = 3'(i);
        in_stock = (cnt[i] != '0);
      end
    end
  end

  always_comb begin
    state_n  = state_q;
    credit_n = credit_q;
    rej_n    = 1'b0;
    deny_n   = 1'b0;
    id_n     = '0;
    dec      = '0;
    load     = 1'b0;
    unique case (state_q)
      IDLE: begin
        load     = bus.refill;
        credit_n = acc[CREDIT_W-1:0];
        rej_n    = acc_rej;
        if (acc != {1'b0, credit_q}) state_n = CREDIT;
      end
      CREDIT: begin
        load = bus.refill;
        if (bus.cancel) begin
          rej_n   = coins;
          state_n = (credit_q != '0) ? CHANGE : IDLE;
        end else if (|bus.btn && credit_q >= PRICE_V && in_stock) begin
          credit_n = credit_q - PRICE_V;
          dec      = grant;
          id_n     = sel_id;
          rej_n    = coins;
          state_n  = VEND;
        end else begin
          deny_n   = |bus.btn;
          credit_n = acc[CREDIT_W-1:0];
          rej_n    = acc_rej;
        end
      end
      VEND: begin
        rej_n   = coins;
        state_n = (credit_q != '0) ? CHANGE : IDLE;
      end
      CHANGE: begin
        rej_n    = coins;
        credit_n = credit_q - 1'b1;
        if (credit_q <= CREDIT_W'(1)) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state_q  <= IDLE;
      credit_q <= '0;
      rej_q    <= 1'b0;
      deny_q   <= 1'b0;
      id_q     <= '0;
    end else begin
      state_q  <= state_n;
      credit_q <= credit_n;
      rej_q    <= rej_n;
      deny_q   <= deny_n;
      id_q     <= id_n;
    end
  end

  assign bus.sale     = (state_q == VEND);
  assign bus.sale_id  = id_q;
  assign bus.ret      = (state_q == CHANGE);
  assign bus.coin_rej = rej_q;
  assign bus.deny     = deny_q;
  assign bus.credit   = credit_q;
  assign bus.sold_out = empty;
  assign bus.busy     = (state_q == VEND) || (state_q == CHANGE);

endmodule

// File: tb/tb_vending_ctrl.sv
// Directed bench for vending_ctrl: vector table plus multi-cycle sequences.
module tb_vending_ctrl;

  logic CLK  = 1'b0;
  logic RSTn = 1'b0;
  int   checks = 0;
  int   errors = 0;

  vending_ctrl_if #(.N_PROD(2), .CREDIT_W(4)) bus ();

  vending_ctrl #(
    .PRICE(3), .MAX_CREDIT(10), .CREDIT_W(4),
    .N_PROD(2), .STOCK_INIT(8), .STOCK_W(4)
  ) dut (
    .CLK (CLK),
    .RSTn(RSTn),
    .bus (bus)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic       w100, w500;
    logic [1:0] btn;
    logic       cancel, refill;
    int         credit, sale, sale_id, ret, rej, deny, sold_out, busy;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic w1, logic w5, logic [1:0] b, logic c, logic r,
                              int cr, int s, int sid, int rt, int rj, int dn,
                              int so, int bz);
    vec_t v;
    v.w100 = w1; v.w500 = w5; v.btn = b; v.cancel = c; v.refill = r;
    v.credit = cr; v.sale = s; v.sale_id = sid; v.ret = rt; v.rej = rj;
    v.deny = dn; v.sold_out = so; v.busy = bz;
    return v;
  endfunction

  task automatic chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic drive(logic w1, logic w5, logic [1:0] b, logic c, logic r);
    bus.w100 = w1; bus.w500 = w5; bus.btn = b; bus.cancel = c; bus.refill = r;
    @(posedge CLK);
    #1;
    bus.w100 = 1'b0; bus.w500 = 1'b0; bus.btn = '0; bus.cancel = 1'b0; bus.refill = 1'b0;
  endtask

  task automatic chk_all(string tag, vec_t v);
    chk({tag, " credit"},   int'(bus.credit),   v.credit);
    chk({tag, " sale"},     int'(bus.sale),     v.sale);
    chk({tag, " sale_id"},  int'(bus.sale_id),  v.sale_id);
    chk({tag, " ret"},      int'(bus.ret),      v.ret);
    chk({tag, " coin_rej"}, int'(bus.coin_rej), v.rej);
    chk({tag, " deny"},     int'(bus.deny),     v.deny);
    chk({tag, " sold_out"}, int'(bus.sold_out), v.sold_out);
    chk({tag, " busy"},     int'(bus.busy),     v.busy);
  endtask

  task automatic cancel_drain(string tag, int c, int so);
    drive(1'b0, 1'b0, 2'b00, 1'b1, 1'b0);
    chk_all($sformatf("%s c%0d", tag, c), mk(0,0,0,0,0, c,0,0,1,0,0,so,1));
    for (int k = c - 1; k >= 1; k--) begin
      drive(1'b0, 1'b0, 2'b00, 1'b0, 1'b0);
      chk_all($sformatf("%s c%0d", tag, k), mk(0,0,0,0,0, k,0,0,1,0,0,so,1));
    end
    drive(1'b0, 1'b0, 2'b00, 1'b0, 1'b0);
    chk_all($sformatf("%s end", tag), mk(0,0,0,0,0, 0,0,0,0,0,0,so,0));
  endtask

  // Insert exactly PRICE with three w100 coins and buy product p.
  task automatic sell(string tag, int p, int so_after);
    for (int k = 1; k <= 3; k++) begin
      drive(1'b1, 1'b0, 2'b00, 1'b0, 1'b0);
      chk($sformatf("%s coin%0d credit", tag, k), int'(bus.credit), k);
    end
    drive(1'b0, 1'b0, (p == 0) ? 2'b01 : 2'b10, 1'b0, 1'b0);
    chk({tag, " sale"},     int'(bus.sale),     1);
    chk({tag, " sale_id"},  int'(bus.sale_id),  p);
    chk({tag, " credit"},   int'(bus.credit),   0);
    chk({tag, " sold_out"}, int'(bus.sold_out), so_after);
    drive(1'b0, 1'b0, 2'b00, 1'b0, 1'b0);
    chk({tag, " idle ret"},  int'(bus.ret),  0);
    chk({tag, " idle busy"}, int'(bus.busy), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: got 1, expected 0");
    $fatal(1, "timeout");
  end

  initial begin
    bus.w100 = 1'b0; bus.w500 = 1'b0; bus.btn = '0; bus.cancel = 1'b0; bus.refill = 1'b0;

    // Purchase with change
    vecs.push_back(mk(1,0,2'b00,0,0, 1,0,0,0,0,0,0,0));
    vecs.push_back(mk(1,0,2'b00,0,0, 2,0,0,0,0,0,0,0));
    vecs.push_back(mk(0,1,2'b00,0,0, 7,0,0,0,0,0,0,0));
    vecs.push_back(mk(0,0,2'b01,0,0, 4,1,0,0,0,0,0,1));
    vecs.push_back(mk(0,0,2'b00,0,0, 4,0,0,1,0,0,0,1));
    vecs.push_back(mk(0,0,2'b00,0,0, 3,0,0,1,0,0,0,1));
    vecs.push_back(mk(0,0,2'b00,0,0, 2,0,0,1,0,0,0,1));
    vecs.push_back(mk(0,0,2'b00,0,0, 1,0,0,1,0,0,0,1));
    vecs.push_back(mk(0,0,2'b00,0,0, 0,0,0,0,0,0,0,0));
    // btn and cancel in IDLE are ignored
    vecs.push_back(mk(0,0,2'b01,1,0, 0,0,0,0,0,0,0,0));
    // Low credit deny, then cancel
    vecs.push_back(mk(1,0,2'b00,0,0, 1,0,0,0,0,0,0,0));
    vecs.push_back(mk(1,0,2'b00,0,0, 2,0,0,0,0,0,0,0));
    vecs.push_back(mk(0,0,2'b10,0,0, 2,0,0,0,0,1,0,0));
    vecs.push_back(mk(0,0,2'b00,1,0, 2,0,0,1,0,0,0,1));
    vecs.push_back(mk(0,0,2'b00,0,0, 1,0,0,1,0,0,0,1));
    vecs.push_back(mk(0,0,2'b00,0,0, 0,0,0,0,0,0,0,0));
    // Both buttons plus a coin in the sale cycle
    vecs.push_back(mk(1,0,2'b00,0,0, 1,0,0,0,0,0,0,0));
    vecs.push_back(mk(1,0,2'b00,0,0, 2,0,0,0,0,0,0,0));
    vecs.push_back(mk(1,0,2'b00,0,0, 3,0,0,0,0,0,0,0));
    vecs.push_back(mk(1,0,2'b11,0,0, 0,1,0,0,1,0,0,1));
    vecs.push_back(mk(0,0,2'b00,0,0, 0,0,0,0,0,0,0,0));
    // Credit ceiling
    vecs.push_back(mk(0,1,2'b00,0,0, 5,0,0,0,0,0,0,0));
    vecs.push_back(mk(1,0,2'b00,0,0, 6,0,0,0,0,0,0,0));
    vecs.push_back(mk(1,0,2'b00,0,0, 7,0,0,0,0,0,0,0));
    vecs.push_back(mk(0,1,2'b00,0,0, 7,0,0,0,1,0,0,0));
    vecs.push_back(mk(1,0,2'b00,0,0, 8,0,0,0,0,0,0,0));
    vecs.push_back(mk(1,0,2'b00,0,0, 9,0,0,0,0,0,0,0));
    vecs.push_back(mk(1,0,2'b00,0,0, 10,0,0,0,0,0,0,0));
    vecs.push_back(mk(1,0,2'b00,0,0, 10,0,0,0,1,0,0,0));

    repeat (2) @(posedge CLK);
    #1;
    chk_all("reset", mk(0,0,0,0,0, 0,0,0,0,0,0,0,0));
    RSTn = 1'b1;
    @(posedge CLK);
    #1;

    foreach (vecs[i]) begin
      drive(vecs[i].w100, vecs[i].w500, vecs[i].btn, vecs[i].cancel, vecs[i].refill);
      chk_all($sformatf("row%0d", i), vecs[i]);
    end

    cancel_drain("drain10", 10, 0);

    // Exhaust product 1, then refused, then refill
    for (int n = 1; n <= 8; n++)
      sell($sformatf("p1 sale%0d", n), 1, (n == 8) ? 2 : 0);
    for (int k = 1; k <= 3; k++) drive(1'b1, 1'b0, 2'b00, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 2'b10, 1'b0, 1'b0);
    chk_all("soldout deny", mk(0,0,0,0,0, 3,0,0,0,0,1,2,0));
    drive(1'b0, 1'b0, 2'b00, 1'b0, 1'b1);
    chk_all("refill", mk(0,0,0,0,0, 3,0,0,0,0,0,0,0));
    cancel_drain("drain3", 3, 0);

    // Reset in the middle of change return
    drive(1'b0, 1'b1, 2'b00, 1'b0, 1'b0);
    chk("rst pre credit", int'(bus.credit), 5);
    drive(1'b0, 1'b0, 2'b00, 1'b1, 1'b0);
    chk("rst ret1", int'(bus.ret), 1);
    drive(1'b0, 1'b0, 2'b00, 1'b0, 1'b0);
    chk("rst ret2", int'(bus.ret), 1);
    chk("rst ret2 credit", int'(bus.credit), 4);
    #1 RSTn = 1'b0;
    #1;
    chk_all("async rst", mk(0,0,0,0,0, 0,0,0,0,0,0,0,0));
    @(negedge CLK);
    RSTn = 1'b1;
    @(posedge CLK);
    #1;
    chk("post rst ret", int'(bus.ret), 0);
    // Product 0 must have a full stock of 8 again
    for (int n = 1; n <= 8; n++)
      sell($sformatf("p0 sale%0d", n), 0, (n == 8) ? 1 : 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
